// File: rtl/parity_serializer.sv
// Frames a WIDTH-bit word as start / data LSB-first / parity / stop with a one-word hold buffer.
// Latency: START appears the cycle after accept; a frame lasts WIDTH+3 cycles and all outputs are registered.
// Backpressure: load_ready drops while the hold buffer is occupied, so no word is ever overwritten.
module parity_serializer #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             parity_q, parity_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             load_ready_q, load_ready_d;
    logic             accept;
    logic             direct;

    assign accept = load_valid && load_ready_q;
    // A word bypasses the hold buffer only when the shifter is free at this edge.
    assign direct = accept && ((state_q == IDLE) || ((state_q == STOP) && !hold_full_q));

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        parity_d    = parity_q;
        cnt_d       = cnt_q;

        if (accept && !direct) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE, STOP: begin
                state_d = IDLE;
                if (direct) begin
                    shift_d  = data_in;
                    parity_d = (^data_in) ^ ODD_BIT;
                    state_d  = START;
                end else if (hold_full_q) begin
                    shift_d     = hold_q;
                    parity_d    = (^hold_q) ^ ODD_BIT;
                    hold_full_d = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = PARITY;
                end
            end
            PARITY:  state_d = STOP;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        out_d        = 1'b1;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = (state_d != IDLE);
        load_ready_d = !hold_full_d;
        case (state_d)
            START:  out_d = 1'b0;
            DATA: begin
                out_d       = shift_d[0];
                out_valid_d = 1'b1;
            end
            PARITY: begin
                out_d       = parity_d;
                out_valid_d = 1'b1;
            end
            STOP:    frame_done_d = 1'b1;
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            parity_q     <= 1'b0;
            cnt_q        <= '0;
            out_q        <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            parity_q     <= parity_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Directed bench for parity_serializer: an even-parity and an odd-parity instance share one stimulus.
module tb_parity_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;

    logic e_rdy, e_out, e_ovld, e_busy, e_fd;
    logic o_rdy, o_out, o_ovld, o_busy, o_fd;

    int checks = 0;
    int errors = 0;

    logic acc = 1'b0;
    logic acc_en = 1'b0;
    int   fd_seen = 0;

    always #5 clk = ~clk;

    parity_serializer #(.WIDTH(8), .ODD(0)) u_even (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(e_rdy), .out(e_out), .out_valid(e_ovld), .busy(e_busy), .frame_done(e_fd)
    );

    parity_serializer #(.WIDTH(8), .ODD(1)) u_odd (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
        .load_ready(o_rdy), .out(o_out), .out_valid(o_ovld), .busy(o_busy), .frame_done(o_fd)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream even-parity accumulator gated by out_valid.
    always @(negedge clk) begin
        if (!reset) begin
            acc = 1'b0;
        end else begin
            if (acc_en && e_fd) begin
                chk("acc_at_frame_done", acc, 1'b0);
                fd_seen++;
            end
            if (e_ovld) acc = acc ^ e_out;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po);
        int vcnt;
        int fdcnt;
        vcnt  = 0;
        fdcnt = 0;
        data_in    = d;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("start_out", e_out, 1'b0);
        chk("start_ovld", e_ovld, 1'b0);
        chk("start_busy", e_busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("data_bit", e_out, d[i]);
            vcnt  += int'(e_ovld);
            fdcnt += int'(e_fd);
        end
        tick();
        chk("parity_even", e_out, pe);
        chk("parity_odd", o_out, po);
        vcnt  += int'(e_ovld);
        fdcnt += int'(e_fd);
        tick();
        chk("stop_out", e_out, 1'b1);
        chk("stop_frame_done", e_fd, 1'b1);
        chk("stop_ovld", e_ovld, 1'b0);
        chk("ovld_cycles", vcnt, 9);
        chk("frame_done_early", fdcnt, 0);
        tick();
        chk("idle_out", e_out, 1'b1);
        chk("idle_busy", e_busy, 1'b0);
        chk("idle_frame_done", e_fd, 1'b0);
    endtask

    initial begin
        logic [32:0] exp_stream;
        logic [32:0] got_stream;
        logic [7:0]  words [3];
        logic [7:0]  w;
        int          idx;
        int          rdy_low;
        int          busy_hi;
        int          stray;
        logic        rdy_before;

        // Reset held two cycles with a word on offer.
        reset      = 1'b0;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        tick();
        tick();
        chk("rst_out", e_out, 1'b1);
        chk("rst_ready", e_rdy, 1'b1);
        chk("rst_busy", e_busy, 1'b0);
        chk("rst_ovld", e_ovld, 1'b0);
        chk("rst_frame_done", e_fd, 1'b0);
        reset      = 1'b1;
        load_valid = 1'b0;
        stray      = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            stray += int'(e_busy) + int'(!e_out);
        end
        chk("no_frame_after_rst", stray, 0);

        // Single frames with hand-computed parity (even, odd).
        send_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1);

        // Back-to-back: three words offered continuously.
        words[0] = 8'h01;
        words[1] = 8'h80;
        words[2] = 8'hFF;
        exp_stream = {{1'b1, 1'b0, 8'hFF, 1'b0},
                      {1'b1, 1'b1, 8'h80, 1'b0},
                      {1'b1, 1'b1, 8'h01, 1'b0}};
        idx     = 0;
        rdy_low = 0;
        busy_hi = 0;
        got_stream = '0;
        for (int cyc = 0; cyc < 33; cyc++) begin
            load_valid = (idx < 3);
            data_in    = (idx < 3) ? words[idx] : 8'h00;
            rdy_before = e_rdy;
            tick();
            if (load_valid && rdy_before) idx++;
            got_stream[cyc] = e_out;
            rdy_low += int'(!e_rdy);
            busy_hi += int'(e_busy);
        end
        load_valid = 1'b0;
        chk("b2b_stream", got_stream, exp_stream);
        chk("b2b_accepted", idx, 3);
        chk("b2b_ready_low_cycles", rdy_low, 20);
        chk("b2b_busy_cycles", busy_hi, 33);
        tick();
        chk("b2b_idle_after", e_busy, 1'b0);

        // Reset during data bit 3 with a second word held.
        data_in    = 8'h55;
        load_valid = 1'b1;
        tick();
        data_in = 8'hAA;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_ready_low", e_rdy, 1'b0);
        chk("mid_bit3", e_out, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_out", e_out, 1'b1);
        chk("mid_rst_busy", e_busy, 1'b0);
        chk("mid_rst_ready", e_rdy, 1'b1);
        chk("mid_rst_ovld", e_ovld, 1'b0);
        stray = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            stray += int'(e_busy) + int'(e_ovld);
        end
        chk("held_word_dropped", stray, 0);
        send_frame(8'h3C, 1'b0, 1'b1);

        // Random words through the downstream accumulator.
        acc_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            w = 8'($urandom);
            send_frame(w, ^w, ~^w);
        end
        acc_en = 1'b0;
        chk("acc_frames_seen", fd_seen, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
